// File: rtl/rssb_mem_arbiter.sv
// rssb_mem_arbiter: shares one synchronous data memory between the RSSB core
// datapath and a host loader/debug port, with an exclusive host lock.
// Optional build macro: RSSB_ARB_RR_EN selects round-robin tie-break in the
// shared state; when undefined the host always wins a tie.
module rssb_mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic              o_core_gnt,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_stall,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_gnt,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata,
  input  logic              i_host_lock_req,
  output logic              o_host_lock_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_SHARED = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic LG_CORE = 1'b0;
  localparam logic LG_HOST = 1'b1;

  state_t            r_state;
  logic              r_lock_ack;
  logic              r_last_gnt;
  logic              r_core_rd;
  logic              r_host_rd;

  logic              w_host_wins;
  logic              w_core_gnt;
  logic              w_host_gnt;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

`ifdef RSSB_ARB_RR_EN
  // Round-robin: on a tie the requester not served last time wins.
  assign w_host_wins = (r_last_gnt == LG_CORE);
`else
  // Fixed priority: host wins every tie; grant history does not matter.
  assign w_host_wins = r_last_gnt | 1'b1;
`endif

  // Grant selection: one access per cycle, none while reset is asserted.
  always_comb begin
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_SHARED: begin
          if (i_core_req && i_host_req) begin
            w_host_gnt = w_host_wins;
            w_core_gnt = ~w_host_wins;
          end else begin
            w_host_gnt = i_host_req;
            w_core_gnt = i_core_req;
          end
        end
        ST_DRAIN, ST_LOCKED: w_host_gnt = i_host_req;
        default: begin
          w_core_gnt = 1'b0;
          w_host_gnt = 1'b0;
        end
      endcase
    end
  end

  // Memory port mux driven by the granted requester, zero when idle.
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_host_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = i_host_we;
      w_mem_addr  = i_host_addr;
      w_mem_wdata = i_host_wdata;
    end else if (w_core_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = i_core_we;
      w_mem_addr  = i_core_addr;
      w_mem_wdata = i_core_wdata;
    end
  end

  // Lock FSM: SHARED -> DRAIN -> LOCKED, ack registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_SHARED;
      r_lock_ack <= 1'b0;
    end else begin
      case (r_state)
        ST_SHARED: begin
          if (i_host_lock_req) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_state    <= ST_LOCKED;
          r_lock_ack <= 1'b1;
        end
        ST_LOCKED: begin
          if (!i_host_lock_req) begin
            r_state    <= ST_SHARED;
            r_lock_ack <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_SHARED;
          r_lock_ack <= 1'b0;
        end
      endcase
    end
  end

  // Read-return ownership and last-granted requester history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_rd  <= 1'b0;
      r_host_rd  <= 1'b0;
      r_last_gnt <= LG_HOST;
    end else begin
      r_core_rd <= w_core_gnt & ~i_core_we;
      r_host_rd <= w_host_gnt & ~i_host_we;
      if (w_host_gnt) begin
        r_last_gnt <= LG_HOST;
      end else if (w_core_gnt) begin
        r_last_gnt <= LG_CORE;
      end
    end
  end

  assign o_core_gnt      = w_core_gnt;
  assign o_host_gnt      = w_host_gnt;
  assign o_core_stall    = i_core_req & ~w_core_gnt & ~rst;
  assign o_core_rvalid   = r_core_rd;
  assign o_host_rvalid   = r_host_rd;
  assign o_core_rdata    = r_core_rd ? i_mem_rdata : '0;
  assign o_host_rdata    = r_host_rd ? i_mem_rdata : '0;
  assign o_host_lock_ack = r_lock_ack;
  assign o_mem_en        = w_mem_en;
  assign o_mem_we        = w_mem_we;
  assign o_mem_addr      = w_mem_addr;
  assign o_mem_wdata     = w_mem_wdata;

endmodule

// File: tb/tb_rssb_mem_arbiter.sv
// Directed bench for rssb_mem_arbiter: vector table for single-cycle
// arbitration plus sequences for reset, ties, lock handshake and drain.
module tb_rssb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       core_req, core_we, core_gnt, core_rvalid, core_stall;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       host_req, host_we, host_gnt, host_rvalid;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       lock_req, lock_ack;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  rssb_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid),
    .o_core_rdata(core_rdata), .o_core_stall(core_stall),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid),
    .o_host_rdata(host_rdata),
    .i_host_lock_req(lock_req), .o_host_lock_ack(lock_ack),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after strobe.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       creq; logic cwe; logic [7:0] caddr; logic [7:0] cwd;
    logic       hreq; logic hwe; logic [7:0] haddr; logic [7:0] hwd;
    logic       e_cg; logic e_hg; logic e_en; logic e_we;
    logic [7:0] e_addr; logic [7:0] e_wd; logic e_stall;
    logic       e_crv; logic [7:0] e_crd; logic e_hrv; logic [7:0] e_hrd;
  } vec_t;

  vec_t vt [8];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  initial begin
    // Vector table: applied in SHARED state, rvalid fields refer to the prior row.
`ifdef RSSB_ARB_RR_EN
    vt[0] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,8'h00,1'b0,8'h00};
`else
    vt[0] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,8'h00,1'b1,8'h00};
`endif
    vt[1] = '{1'b1,1'b1,8'h05,8'h3C, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b1,8'h05,8'h3C,1'b0, 1'b0,8'h00,1'b0,8'h00};
    vt[2] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h20,8'h5A, 1'b0,1'b1,1'b1,1'b1,8'h20,8'h5A,1'b0, 1'b0,8'h00,1'b0,8'h00};
`ifdef RSSB_ARB_RR_EN
    vt[3] = '{1'b1,1'b0,8'h06,8'h00, 1'b1,1'b0,8'h21,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h06,8'h00,1'b0, 1'b0,8'h00,1'b0,8'h00};
    vt[4] = '{1'b1,1'b1,8'h07,8'h01, 1'b1,1'b1,8'h22,8'h02, 1'b0,1'b1,1'b1,1'b1,8'h22,8'h02,1'b1, 1'b1,8'h00,1'b0,8'h00};
`else
    vt[3] = '{1'b1,1'b0,8'h06,8'h00, 1'b1,1'b0,8'h21,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h21,8'h00,1'b1, 1'b0,8'h00,1'b0,8'h00};
    vt[4] = '{1'b1,1'b1,8'h07,8'h01, 1'b1,1'b1,8'h22,8'h02, 1'b0,1'b1,1'b1,1'b1,8'h22,8'h02,1'b1, 1'b0,8'h00,1'b1,8'h00};
`endif
    vt[5] = '{1'b1,1'b0,8'h05,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h05,8'h00,1'b0, 1'b0,8'h00,1'b0,8'h00};
    vt[6] = '{1'b0,1'b1,8'hFF,8'hEE, 1'b1,1'b0,8'h20,8'h99, 1'b0,1'b1,1'b1,1'b0,8'h20,8'h99,1'b0, 1'b1,8'h3C,1'b0,8'h00};
    vt[7] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,8'h00,1'b1,8'h5A};

    // Reset held with both requesting: nothing may be granted.
    rst = 1'b1;
    lock_req = 1'b0;
    drive(1'b1, 1'b0, 8'h41, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_core_gnt", core_gnt, 1'b0);
    chk1("rst_host_gnt", host_gnt, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_ack", lock_ack, 1'b0);
    chk1("rst_stall", core_stall, 1'b0);
    chk1("rst_core_rvalid", core_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
`ifdef RSSB_ARB_RR_EN
    chk1("post_rst_core_gnt", core_gnt, 1'b1);
    chk1("post_rst_host_gnt", host_gnt, 1'b0);
`else
    chk1("post_rst_core_gnt", core_gnt, 1'b0);
    chk1("post_rst_host_gnt", host_gnt, 1'b1);
`endif
    tick();

    // Table-driven single-cycle arbitration.
    for (int v = 0; v < 8; v++) begin
      drive(vt[v].creq, vt[v].cwe, vt[v].caddr, vt[v].cwd,
            vt[v].hreq, vt[v].hwe, vt[v].haddr, vt[v].hwd);
      @(negedge clk);
      chk1($sformatf("v%0d_core_gnt", v), core_gnt, vt[v].e_cg);
      chk1($sformatf("v%0d_host_gnt", v), host_gnt, vt[v].e_hg);
      chk1($sformatf("v%0d_mem_en", v), mem_en, vt[v].e_en);
      chk1($sformatf("v%0d_mem_we", v), mem_we, vt[v].e_we);
      chk8($sformatf("v%0d_mem_addr", v), mem_addr, vt[v].e_addr);
      chk8($sformatf("v%0d_mem_wdata", v), mem_wdata, vt[v].e_wd);
      chk1($sformatf("v%0d_stall", v), core_stall, vt[v].e_stall);
      chk1($sformatf("v%0d_core_rvalid", v), core_rvalid, vt[v].e_crv);
      chk8($sformatf("v%0d_core_rdata", v), core_rdata, vt[v].e_crd);
      chk1($sformatf("v%0d_host_rvalid", v), host_rvalid, vt[v].e_hrv);
      chk8($sformatf("v%0d_host_rdata", v), host_rdata, vt[v].e_hrd);
      tick();
    end

    // Four-cycle tie; last grant before this was to the host.
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
`ifdef RSSB_ARB_RR_EN
      chk1($sformatf("tie%0d_host_gnt", c), host_gnt, (c % 2) == 1);
      chk1($sformatf("tie%0d_stall", c), core_stall, (c % 2) == 1);
`else
      chk1($sformatf("tie%0d_host_gnt", c), host_gnt, 1'b1);
      chk1($sformatf("tie%0d_stall", c), core_stall, 1'b1);
`endif
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Lock handshake while the core reads continuously.
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    lock_req = 1'b1;
    @(negedge clk);
    chk1("lockN_core_gnt", core_gnt, 1'b1);
    chk1("lockN_ack", lock_ack, 1'b0);
    tick();
    @(negedge clk);
    chk1("lockN1_core_gnt", core_gnt, 1'b0);
    chk1("lockN1_stall", core_stall, 1'b1);
    chk1("lockN1_core_rvalid", core_rvalid, 1'b1);
    chk8("lockN1_core_rdata", core_rdata, 8'h3C);
    chk1("lockN1_ack", lock_ack, 1'b0);
    tick();
    @(negedge clk);
    chk1("lockN2_ack", lock_ack, 1'b1);
    chk1("lockN2_core_gnt", core_gnt, 1'b0);
    chk1("lockN2_core_rvalid", core_rvalid, 1'b0);
    tick();

    // Host write then read-back while locked.
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    chk1("lk_wr_host_gnt", host_gnt, 1'b1);
    chk1("lk_wr_core_gnt", core_gnt, 1'b0);
    chk8("lk_wr_mem_addr", mem_addr, 8'h10);
    tick();
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk1("lk_rd_host_gnt", host_gnt, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("lk_rd_host_rvalid", host_rvalid, 1'b1);
    chk8("lk_rd_host_rdata", host_rdata, 8'hA5);
    chk1("lk_rd_core_rvalid", core_rvalid, 1'b0);
    tick();
    lock_req = 1'b0;
    @(negedge clk);
    chk1("relM_ack", lock_ack, 1'b1);
    chk1("relM_core_gnt", core_gnt, 1'b0);
    tick();
    @(negedge clk);
    chk1("relM1_ack", lock_ack, 1'b0);
    chk1("relM1_core_gnt", core_gnt, 1'b1);
    tick();

    // One-cycle lock pulse still passes through LOCKED once.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    @(negedge clk);
    chk1("pulse_drain_ack", lock_ack, 1'b0);
    tick();
    @(negedge clk);
    chk1("pulse_locked_ack", lock_ack, 1'b1);
    tick();
    @(negedge clk);
    chk1("pulse_release_ack", lock_ack, 1'b0);
    tick();

    // Reset while locked with a host read outstanding.
    lock_req = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk1("rl_ack", lock_ack, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk1("rl_host_gnt", host_gnt, 1'b1);
    tick();
    chk1("rl_host_rvalid_pending", host_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rl_ack_drop", lock_ack, 1'b0);
    chk1("rl_rvalid_drop", host_rvalid, 1'b0);
    chk1("rl_mem_en_drop", mem_en, 1'b0);
    chk1("rl_host_gnt_drop", host_gnt, 1'b0);
    @(negedge clk);
    lock_req = 1'b0;
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    #1;
    chk1("rl_after_core_gnt", core_gnt, 1'b1);
    chk1("rl_after_ack", lock_ack, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rssb_mem_arbiter.md
# rssb_mem_arbiter

Single-port memory arbiter for the RSSB processor. It shares the one synchronous data memory between the core datapath (operand fetch and result write-back) and a host loader/debug port. It also provides an exclusive host lock so programs can be loaded or inspected while the core is frozen. It drives a stall to the core sequencer whenever a core access is not granted.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- core_req / host_req  in  1  access request, held until granted
- core_we / host_we  in  1  1 = write, 0 = read
- core_addr / host_addr  in  ADDR_W  access address
- core_wdata / host_wdata  in  DATA_W  write data
- core_gnt / host_gnt  out  1  access issued to memory this cycle
- core_rvalid / host_rvalid  out  1  read data valid on rdata this cycle
- core_rdata / host_rdata  out  DATA_W  read data, routed from mem_rdata
- core_stall  out  1  core_req & ~core_gnt
- host_lock_req  in  1  host requests exclusive ownership
- host_lock_ack  out  1  registered; memory exclusively owned by host
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W
- mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  valid the cycle after a read strobe

## Operation
- FSM states: SHARED, DRAIN, LOCKED.
  - SHARED: both requesters arbitrated. host_lock_req=1 goes to DRAIN.
  - DRAIN: core never granted; host arbitrated normally. Next cycle goes to LOCKED unconditionally.
  - LOCKED: only host granted; host_lock_ack=1. host_lock_req=0 goes to SHARED.
  - DRAIN with host_lock_req=0: still goes to LOCKED, then releases on the following edge.
- Grant is combinational from req and state, one access per cycle.
- For the granted requester X:
  - mem_en=1, mem_we=X_we, mem_addr=X_addr, mem_wdata=X_wdata, X_gnt=1.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read return: the owner of a granted read is registered. X_rvalid=1 exactly in the next cycle, with X_rdata=mem_rdata.
  - The non-owner's rdata is 0. Writes produce no rvalid.
- Tie-break in SHARED (both requesting) is fixed priority: host wins, per Configuration.
- last_gnt register records the most recently granted requester.
- Back-to-back grants to the same requester are allowed every cycle.

## Timing
- Reset values:
  - state=SHARED, last_gnt=HOST.
  - All gnt, rvalid, rdata, mem_* = 0. host_lock_ack=0, core_stall=0.
  - While rst=1 no grant is issued regardless of req.
- Grant latency is 0 cycles from req when selected; read latency is 1 cycle from gnt.
- Lock handshake:
  - host_lock_req rises in cycle N. The core may still be granted in N.
  - No core grant from N+1. host_lock_ack=1 from N+2.
  - Any core read granted in N returns in N+1, before ack.
- Release: host_lock_req falls in cycle M. host_lock_ack=0 and core is grantable from M+1.
- Reset mid-lock returns to SHARED with ack=0 immediately (asynchronous). A pending rvalid is discarded.

## Configuration
- RSSB_ARB_RR_EN defined: round-robin tie-break. When both request in SHARED, grant goes to the requester not equal to last_gnt. First tie after reset goes to core.
- RSSB_ARB_RR_EN undefined: fixed priority, host always wins ties. last_gnt is still maintained but unused.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset with core_req=host_req=1 held -> all gnt=0, mem_en=0, host_lock_ack=0. After release, first grant occurs in the next cycle.
- Core read addr 0x05, memory[0x05]=0x3C -> core_gnt=1 and mem_addr=0x05 in cycle N; core_rvalid=1 and core_rdata=0x3C in N+1; host_rvalid=0.
- Both request for 4 consecutive cycles:
  - Fixed build: H,H,H,H with core_stall=1 throughout.
  - RSSB_ARB_RR_EN build: C,H,C,H with core_stall=1 in cycles 2 and 4.
- Core reading continuously, host_lock_req rises at N -> core_gnt=1 at N, core_rvalid at N+1, core_gnt=0 and core_stall=1 from N+1, host_lock_ack=1 at N+2.
- In LOCKED, host writes 0xA5 to 0x10 then reads it back -> host_rvalid=1 with 0xA5. Drop host_lock_req at M -> ack=0 and core_gnt=1 at M+1.
- Assert rst while LOCKED with a host read outstanding -> ack, rvalid and mem_en drop to 0 immediately. State is SHARED after release.
